// File: rtl/bcd_disp_pkg.sv
// Shared segment encodings for the BCD seven-segment scanner.
// Segment bit order is {g,f,e,d,c,b,a}. Segments are active-high.
package bcd_disp_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_0    = 7'h3F;
   localparam seg_t SEG_1    = 7'h06;
   localparam seg_t SEG_2    = 7'h5B;
   localparam seg_t SEG_3    = 7'h4F;
   localparam seg_t SEG_4    = 7'h66;
   localparam seg_t SEG_5    = 7'h6D;
   localparam seg_t SEG_6    = 7'h7D;
   localparam seg_t SEG_7    = 7'h07;
   localparam seg_t SEG_8    = 7'h7F;
   localparam seg_t SEG_9    = 7'h6F;
   localparam seg_t SEG_DASH = 7'h40;
   localparam seg_t SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to seven-segment decoder.
// Codes A..F are not valid BCD digits, so they show a dash.
module bcd_to_seg
   import bcd_disp_pkg::*;
(
   input  logic [3:0] code,
   output seg_t       seg
);

   // Look up the segment pattern for one 4-bit code
   always_comb begin
      seg = SEG_DASH;
      case (code)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_digit_scanner.sv
// Time-multiplexed seven-segment scanner for a bank of BCD digits.
// A value loaded mid-frame waits in a pending register and is copied
// into the display register at the next frame boundary, so a frame
// never mixes digits from two different values.
module bcd_digit_scanner
   import bcd_disp_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 1000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   bcd_in,
   input  logic                  blank_lz,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_done
);

   localparam int PC_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(PRESCALE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   logic [PC_W-1:0]     pc_q, pc_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [4*DIGITS-1:0] disp_q, disp_d;
   logic [4*DIGITS-1:0] pend_q, pend_d;
   logic                pvalid_q, pvalid_d;
   seg_t                seg_q, seg_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic                frame_done_q, frame_done_d;

   logic                tick;
   logic                fb;
   logic [3:0]          cur_code;
   logic                cur_blank;
   logic [DIGITS-1:0]   upper_zero;
   logic                zero_acc;
   seg_t                dec_seg;

   // Prescaler and digit index; the frame boundary is the last tick of the last digit
   always_comb begin
      tick  = (pc_q == PC_LAST);
      fb    = tick && (idx_q == IDX_LAST);
      pc_d  = pc_q + PC_W'(1);
      idx_d = idx_q;
      if (tick) begin
         pc_d  = '0;
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
   end

   // Load capture: a load on the boundary bypasses pend and drops any stale value
   always_comb begin
      disp_d   = disp_q;
      pend_d   = pend_q;
      pvalid_d = pvalid_q;
      if (load && !fb) begin
         pend_d   = bcd_in;
         pvalid_d = 1'b1;
      end else if (load && fb) begin
         disp_d   = bcd_in;
         pvalid_d = 1'b0;
      end else if (fb && pvalid_q) begin
         disp_d   = pend_q;
         pvalid_d = 1'b0;
      end
   end

   // Select the lit digit and decide blanking from the displayed value only
   always_comb begin
      zero_acc   = 1'b1;
      upper_zero = '0;
      cur_code   = 4'd0;
      cur_blank  = 1'b0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         zero_acc      = zero_acc && (disp_q[4*k +: 4] == 4'd0);
         upper_zero[k] = zero_acc;
      end
      for (int k = 0; k < DIGITS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            cur_code  = disp_q[4*k +: 4];
            cur_blank = (k != 0) && upper_zero[k];
         end
      end
   end

   bcd_to_seg u_dec (
      .code (cur_code),
      .seg  (dec_seg)
   );

   // Output register inputs: segments, one-hot anode and boundary pulse
   always_comb begin
      seg_d        = (blank_lz && cur_blank) ? SEG_OFF : dec_seg;
      frame_done_d = fb;
      an_d         = '0;
      for (int k = 0; k < DIGITS; k++) begin
         an_d[k] = (idx_q == IDX_W'(k));
      end
   end

   // State and output registers, all cleared by the asynchronous reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q         <= '0;
         idx_q        <= '0;
         disp_q       <= '0;
         pend_q       <= '0;
         pvalid_q     <= 1'b0;
         seg_q        <= SEG_OFF;
         an_q         <= '0;
         frame_done_q <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         idx_q        <= idx_d;
         disp_q       <= disp_d;
         pend_q       <= pend_d;
         pvalid_q     <= pvalid_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign frame_done = frame_done_q;

endmodule
